// File: rtl/dual_prio_dispatcher_pkg.sv
// rtl/dual_prio_dispatcher_pkg.sv - shared constants and state encoding for the dual-priority dispatcher
package dual_prio_dispatcher_pkg;

    localparam int N_REQ   = 12;
    localparam int CODE_W  = 4;
    localparam int TIMEOUT = 15;

    localparam logic [CODE_W-1:0] CODE_NONE = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dual_prio_dispatcher_if.sv
// rtl/dual_prio_dispatcher_if.sv - encoder-side request and consumer-side grant signals of the dispatcher
interface dual_prio_dispatcher_if #(
    parameter int CODE_W = 4,
    parameter int N_REQ  = 12
);
    logic              start;
    logic [CODE_W-1:0] first;
    logic [CODE_W-1:0] second;
    logic              ack;
    logic              busy;
    logic              gnt_valid;
    logic [CODE_W-1:0] gnt_code;
    logic [N_REQ-1:0]  gnt_onehot;
    logic              done_tick;
    logic              timeout_tick;

    modport master (
        output start, first, second, ack,
        input  busy, gnt_valid, gnt_code, gnt_onehot, done_tick, timeout_tick
    );

    modport slave (
        input  start, first, second, ack,
        output busy, gnt_valid, gnt_code, gnt_onehot, done_tick, timeout_tick
    );
endinterface

// File: rtl/dual_prio_dispatcher_code_to_onehot.sv
// rtl/dual_prio_dispatcher_code_to_onehot.sv - code k (1..N_REQ) to one-hot bit k-1; 0 or out-of-range gives all zeros
module code_to_onehot #(
    parameter int CODE_W = 4,
    parameter int N_REQ  = 12
) (
    input  logic [CODE_W-1:0] code,
    output logic [N_REQ-1:0]  onehot
);
    always_comb begin
        onehot = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (code == CODE_W'(k)) begin
                onehot[k-1] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dual_prio_dispatcher.sv
// rtl/dual_prio_dispatcher.sv - captures first/second codes and issues them as acked grants; grant timeout under DUAL_PRIO_DISPATCH_TIMEOUT_EN
module dual_prio_dispatcher
    import dual_prio_dispatcher_pkg::*;
#(
    parameter int P_N_REQ   = N_REQ,
    parameter int P_CODE_W  = CODE_W,
    parameter int P_TIMEOUT = TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    dual_prio_dispatcher_if.slave   bus
);
    localparam logic [P_CODE_W-1:0] MAX_CODE = P_CODE_W'(P_N_REQ);

    state_t              state;
    state_t              state_n;
    logic [P_CODE_W-1:0] first_r;
    logic [P_CODE_W-1:0] second_r;
    logic [P_CODE_W-1:0] first_in;
    logic [P_CODE_W-1:0] second_in;
    logic                granting;
    logic                advance;
    logic                expire;

    // Out-of-range codes are treated as "no request" from the moment they are captured.
    assign first_in  = (bus.first  > MAX_CODE) ? CODE_NONE : bus.first;
    assign second_in = (bus.second > MAX_CODE) ? CODE_NONE : bus.second;

    assign granting = (state == GNT1) || (state == GNT2);
    assign advance  = granting && (bus.ack || expire);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            first_r  <= CODE_NONE;
            second_r <= CODE_NONE;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.start) begin
                first_r  <= first_in;
                second_r <= second_in;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.start) state_n = (first_in != CODE_NONE) ? GNT1 : DONE;
            GNT1: if (advance)   state_n = (second_r != CODE_NONE) ? GNT2 : DONE;
            GNT2: if (advance)   state_n = DONE;
            DONE:                state_n = IDLE;
            default:             state_n = IDLE;
        endcase
    end

`ifdef DUAL_PRIO_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(P_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_r;

    // An ack landing on the expiry cycle wins, so no tick is raised for it.
    assign expire = granting && !bus.ack && (wait_cnt == CNT_W'(P_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= expire;
            if (state_n != state) begin
                wait_cnt <= '0;
            end else if (granting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign bus.timeout_tick = timeout_r;
`else
    assign expire           = 1'b0;
    assign bus.timeout_tick = 1'b0;
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.gnt_valid = granting;
    assign bus.done_tick = (state == DONE);
    assign bus.gnt_code  = (state == GNT1) ? first_r  :
                           (state == GNT2) ? second_r : CODE_NONE;

    code_to_onehot #(
        .CODE_W (P_CODE_W),
        .N_REQ  (P_N_REQ)
    ) u_onehot (
        .code   (bus.gnt_code),
        .onehot (bus.gnt_onehot)
    );
endmodule
